dqn_step_scheduler: RTL and testbench

Top-level sequencer for one agent interaction step of the DQN accelerator. Each step it runs the Q-network forward pass, hands the predicted action to the epsilon-greedy selector, drives the environment, commits the transition to replay memory, and periodically launches a training pass. It also keeps the step and episode counters. It sits between the host control registers and the network, epsilon-greedy, environment and replay-memory blocks.

---
 rtl/dqn_pkg.sv | 27 ++
 rtl/dqn_watchdog.sv | 39 +++
 rtl/dqn_step_scheduler.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dqn_step_scheduler.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN accelerator step sequencing logic.
// Contents:
//   - DQN_ACTION_WIDTH / DQN_STEP_WIDTH : default action and counter widths
//   - DQN_ACTION_*                      : action code encoding
//   - dqn_step_state_t                  : step scheduler state encoding
package dqn_pkg;

  localparam int DQN_ACTION_WIDTH = 2;
  localparam int DQN_STEP_WIDTH   = 16;

  // Action codes as produced by the Q-network argmax and the selector.
  localparam logic [1:0] DQN_ACTION_0 = 2'd0;
  localparam logic [1:0] DQN_ACTION_1 = 2'd1;
  localparam logic [1:0] DQN_ACTION_2 = 2'd2;
  localparam logic [1:0] DQN_ACTION_3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREDICT = 3'd1,
    ST_SELECT  = 3'd2,
    ST_ENV     = 3'd3,
    ST_STORE   = 3'd4,
    ST_TRAIN   = 3'd5,
    ST_ERROR   = 3'd6
  } dqn_step_state_t;

endpackage

// File: rtl/dqn_watchdog.sv
// Per-state watchdog for the step scheduler.
// Counts cycles spent in the current state and flags when the count
// reaches LIMIT cycles.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count (state is changing this cycle)
//   en       : current state is a wait state that is being timed
//   expired  : this is the LIMIT-th consecutive cycle in the timed state
module dqn_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_r;

  // cnt_r holds (cycles in state - 1), so LIMIT-1 marks the LIMIT-th cycle.
  assign expired = en && (cnt_r == CW'(LIMIT - 1));

  // Cycle counter: restarts on state change, saturates once expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr || !en) begin
      cnt_r <= {CW{1'b0}};
    end else if (!expired) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/dqn_step_scheduler.sv
// Sequencer for one agent interaction step of the DQN accelerator:
// forward pass -> epsilon-greedy select -> environment -> replay store,
// with a training pass launched every TRAIN_INTERVAL stored transitions.
// Also maintains the per-episode step count and completed-episode count.
//
// Optional feature: define DQN_STEP_TIMEOUT_EN to enable the per-state
// watchdog (o_timeout + ERROR state). Without it o_timeout is constant 0.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_start, i_stop                   host run control
//   o_predict_start / i_predict_done / i_predict_action   Q-network
//   o_eg_valid / o_eg_action / o_eg_train_mode / i_eg_valid / i_eg_action
//                                      epsilon-greedy selector
//   o_env_valid / o_env_action / i_env_done / i_env_terminal  environment
//   o_mem_write / i_mem_ready         replay memory
//   o_train_start / i_train_done      training pass
//   o_step_count, o_episode_count     counters
//   o_busy, o_timeout                 status
module dqn_step_scheduler
  import dqn_pkg::*;
#(
  parameter int ACTION_WIDTH   = DQN_ACTION_WIDTH,
  parameter int STEP_WIDTH     = DQN_STEP_WIDTH,
  parameter int MAX_STEPS      = 200,
  parameter int TRAIN_INTERVAL = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_stop,
  output logic                    o_predict_start,
  input  logic                    i_predict_done,
  input  logic [ACTION_WIDTH-1:0] i_predict_action,
  output logic                    o_eg_valid,
  output logic [ACTION_WIDTH-1:0] o_eg_action,
  output logic                    o_eg_train_mode,
  input  logic                    i_eg_valid,
  input  logic [ACTION_WIDTH-1:0] i_eg_action,
  output logic                    o_env_valid,
  output logic [ACTION_WIDTH-1:0] o_env_action,
  input  logic                    i_env_done,
  input  logic                    i_env_terminal,
  output logic                    o_mem_write,
  input  logic                    i_mem_ready,
  output logic                    o_train_start,
  input  logic                    i_train_done,
  output logic [STEP_WIDTH-1:0]   o_step_count,
  output logic [STEP_WIDTH-1:0]   o_episode_count,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam logic [STEP_WIDTH-1:0] MAX_LIMIT   = STEP_WIDTH'(MAX_STEPS);
  localparam logic [STEP_WIDTH-1:0] TRAIN_LIMIT = STEP_WIDTH'(TRAIN_INTERVAL);

  if (TRAIN_INTERVAL < 1 || MAX_STEPS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("dqn_step_scheduler: invalid parameter value");
  end

  dqn_step_state_t state_r, state_nxt_s;

  logic                    predict_start_r, predict_start_nxt_s;
  logic                    eg_valid_r, eg_valid_nxt_s;
  logic [ACTION_WIDTH-1:0] eg_action_r, eg_action_nxt_s;
  logic                    train_mode_r, train_mode_nxt_s;
  logic                    env_valid_r, env_valid_nxt_s;
  logic [ACTION_WIDTH-1:0] env_action_r, env_action_nxt_s;
  logic                    terminal_r, terminal_nxt_s;
  logic                    mem_write_r, mem_write_nxt_s;
  logic                    train_start_r, train_start_nxt_s;
  logic [STEP_WIDTH-1:0]   step_cnt_r, step_nxt_s;
  logic [STEP_WIDTH-1:0]   episode_cnt_r, episode_nxt_s;
  logic [STEP_WIDTH-1:0]   trans_cnt_r, trans_nxt_s;
  logic                    busy_r, busy_nxt_s;
  logic                    timeout_r, timeout_nxt_s;

  logic                    eos_s;
  logic [STEP_WIDTH-1:0]   eos_step_s;
  logic [STEP_WIDTH-1:0]   step_inc_s;
  logic [STEP_WIDTH-1:0]   trans_inc_s;

  assign step_inc_s  = step_cnt_r + STEP_WIDTH'(1);
  assign trans_inc_s = trans_cnt_r + STEP_WIDTH'(1);

`ifdef DQN_STEP_TIMEOUT_EN
  logic wd_en_s;
  logic wd_clr_s;
  logic wd_expired_s;

  assign wd_en_s  = (state_r != ST_IDLE) && (state_r != ST_ERROR);
  assign wd_clr_s = (state_nxt_s != state_r);

  dqn_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (wd_expired_s)
  );
`endif

  // Next-state and next-output logic for the step sequencer.
  always_comb begin
    state_nxt_s         = state_r;
    predict_start_nxt_s = 1'b0;
    eg_valid_nxt_s      = 1'b0;
    eg_action_nxt_s     = eg_action_r;
    env_action_nxt_s    = env_action_r;
    terminal_nxt_s      = terminal_r;
    train_start_nxt_s   = 1'b0;
    step_nxt_s          = step_cnt_r;
    episode_nxt_s       = episode_cnt_r;
    trans_nxt_s         = trans_cnt_r;
    timeout_nxt_s       = timeout_r;
    eos_s               = 1'b0;
    eos_step_s          = step_cnt_r;

    // A done/valid coinciding with its own request pulse is a stale answer
    // and is ignored, hence the "& !pulse_r" qualifiers below.
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s         = ST_PREDICT;
          predict_start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PREDICT: begin
        if (i_predict_done && !predict_start_r) begin
          eg_action_nxt_s = i_predict_action;
          eg_valid_nxt_s  = 1'b1;
          state_nxt_s     = ST_SELECT;
        end else begin
          state_nxt_s = ST_PREDICT;
        end
      end
      ST_SELECT: begin
        if (i_eg_valid && !eg_valid_r) begin
          env_action_nxt_s = i_eg_action;
          state_nxt_s      = ST_ENV;
        end else begin
          state_nxt_s = ST_SELECT;
        end
      end
      ST_ENV: begin
        if (i_env_done) begin
          terminal_nxt_s = i_env_terminal;
          state_nxt_s    = ST_STORE;
        end else begin
          state_nxt_s = ST_ENV;
        end
      end
      ST_STORE: begin
        if (mem_write_r && i_mem_ready) begin
          step_nxt_s = step_inc_s;
          if (trans_inc_s == TRAIN_LIMIT) begin
            trans_nxt_s       = {STEP_WIDTH{1'b0}};
            train_start_nxt_s = 1'b1;
            state_nxt_s       = ST_TRAIN;
          end else begin
            trans_nxt_s = trans_inc_s;
            eos_s       = 1'b1;
            eos_step_s  = step_inc_s;
          end
        end else begin
          state_nxt_s = ST_STORE;
        end
      end
      ST_TRAIN: begin
        if (i_train_done && !train_start_r) begin
          eos_s      = 1'b1;
          eos_step_s = step_cnt_r;
        end else begin
          state_nxt_s = ST_TRAIN;
        end
      end
      ST_ERROR: begin
        state_nxt_s = ST_ERROR;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // End of step: close the episode if needed, then continue or stop.
    if (eos_s) begin
      if (terminal_r || (eos_step_s == MAX_LIMIT)) begin
        episode_nxt_s = episode_cnt_r + STEP_WIDTH'(1);
        step_nxt_s    = {STEP_WIDTH{1'b0}};
      end else begin
        step_nxt_s = eos_step_s;
      end
      if (i_stop) begin
        state_nxt_s = ST_IDLE;
      end else begin
        state_nxt_s         = ST_PREDICT;
        predict_start_nxt_s = 1'b1;
      end
    end else begin
      eos_step_s = eos_step_s;
    end

`ifdef DQN_STEP_TIMEOUT_EN
    // A timeout only fires when no legitimate transition happens this cycle.
    if (wd_expired_s && (state_nxt_s == state_r)) begin
      state_nxt_s   = ST_ERROR;
      timeout_nxt_s = 1'b1;
    end else begin
      timeout_nxt_s = timeout_r;
    end
`endif

    // Level outputs follow the state being entered, so they are registered.
    env_valid_nxt_s  = (state_nxt_s == ST_ENV);
    mem_write_nxt_s  = (state_nxt_s == ST_STORE);
    train_mode_nxt_s = (state_nxt_s != ST_SELECT);
    busy_nxt_s       = (state_nxt_s != ST_IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      predict_start_r <= 1'b0;
      eg_valid_r      <= 1'b0;
      eg_action_r     <= ACTION_WIDTH'(DQN_ACTION_0);
      train_mode_r    <= 1'b1;
      env_valid_r     <= 1'b0;
      env_action_r    <= ACTION_WIDTH'(DQN_ACTION_0);
      terminal_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      train_start_r   <= 1'b0;
      step_cnt_r      <= {STEP_WIDTH{1'b0}};
      episode_cnt_r   <= {STEP_WIDTH{1'b0}};
      trans_cnt_r     <= {STEP_WIDTH{1'b0}};
      busy_r          <= 1'b0;
      timeout_r       <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      predict_start_r <= predict_start_nxt_s;
      eg_valid_r      <= eg_valid_nxt_s;
      eg_action_r     <= eg_action_nxt_s;
      train_mode_r    <= train_mode_nxt_s;
      env_valid_r     <= env_valid_nxt_s;
      env_action_r    <= env_action_nxt_s;
      terminal_r      <= terminal_nxt_s;
      mem_write_r     <= mem_write_nxt_s;
      train_start_r   <= train_start_nxt_s;
      step_cnt_r      <= step_nxt_s;
      episode_cnt_r   <= episode_nxt_s;
      trans_cnt_r     <= trans_nxt_s;
      busy_r          <= busy_nxt_s;
      timeout_r       <= timeout_nxt_s;
    end
  end

  assign o_predict_start = predict_start_r;
  assign o_eg_valid      = eg_valid_r;
  assign o_eg_action     = eg_action_r;
  assign o_eg_train_mode = train_mode_r;
  assign o_env_valid     = env_valid_r;
  assign o_env_action    = env_action_r;
  assign o_mem_write     = mem_write_r;
  assign o_train_start   = train_start_r;
  assign o_step_count    = step_cnt_r;
  assign o_episode_count = episode_cnt_r;
  assign o_busy          = busy_r;
  assign o_timeout       = timeout_r;

endmodule

// File: tb/tb_dqn_step_scheduler.sv
// Self-checking bench for dqn_step_scheduler. The bench acts as every
// responder (network, selector, environment, memory, trainer) with random
// latencies and keeps its own step/episode/transition bookkeeping.
module tb_dqn_step_scheduler;

  localparam int MAX_STEPS      = 5;
  localparam int TRAIN_INTERVAL = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_stop;
  logic        o_predict_start;
  logic        i_predict_done;
  logic [1:0]  i_predict_action;
  logic        o_eg_valid;
  logic [1:0]  o_eg_action;
  logic        o_eg_train_mode;
  logic        i_eg_valid;
  logic [1:0]  i_eg_action;
  logic        o_env_valid;
  logic [1:0]  o_env_action;
  logic        i_env_done;
  logic        i_env_terminal;
  logic        o_mem_write;
  logic        i_mem_ready;
  logic        o_train_start;
  logic        i_train_done;
  logic [15:0] o_step_count;
  logic [15:0] o_episode_count;
  logic        o_busy;
  logic        o_timeout;

  int n_cmp;
  int n_err;

  // Reference bookkeeping
  logic [15:0] step_m;
  logic [15:0] ep_m;
  int          trans_m;

  dqn_step_scheduler #(
    .ACTION_WIDTH   (2),
    .STEP_WIDTH     (16),
    .MAX_STEPS      (MAX_STEPS),
    .TRAIN_INTERVAL (TRAIN_INTERVAL),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_stop           (i_stop),
    .o_predict_start  (o_predict_start),
    .i_predict_done   (i_predict_done),
    .i_predict_action (i_predict_action),
    .o_eg_valid       (o_eg_valid),
    .o_eg_action      (o_eg_action),
    .o_eg_train_mode  (o_eg_train_mode),
    .i_eg_valid       (i_eg_valid),
    .i_eg_action      (i_eg_action),
    .o_env_valid      (o_env_valid),
    .o_env_action     (o_env_action),
    .i_env_done       (i_env_done),
    .i_env_terminal   (i_env_terminal),
    .o_mem_write      (o_mem_write),
    .i_mem_ready      (i_mem_ready),
    .o_train_start    (o_train_start),
    .i_train_done     (i_train_done),
    .o_step_count     (o_step_count),
    .o_episode_count  (o_episode_count),
    .o_busy           (o_busy),
    .o_timeout        (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  task automatic clear_inputs();
    i_start = 1'b0; i_stop = 1'b0;
    i_predict_done = 1'b0; i_predict_action = 2'd0;
    i_eg_valid = 1'b0; i_eg_action = 2'd0;
    i_env_done = 1'b0; i_env_terminal = 1'b0;
    i_mem_ready = 1'b0; i_train_done = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // One complete step acting as all responders; DUT must be at or heading
  // to a predict request.
  task automatic run_step(input bit term, input bit stop, input bit glitch, input bit slow);
    int n;
    int lat;
    logic [1:0] pa;
    logic [1:0] ca;
    bit train;
    bit exp_go;
    n = 0;
    while (o_predict_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (o_predict_start !== 1'b1) begin
      n_err++;
      $display("FAIL predict_start_seen: got %b want 1", o_predict_start);
      return;
    end
    pa = 2'($urandom_range(0, 3));
    ca = 2'($urandom_range(0, 3));

    // forward pass
    if (glitch) begin
      i_predict_done = 1'b1;
      i_predict_action = ~pa;
      @(negedge clk);
      i_predict_done = 1'b0;
      n_cmp++;
      if (o_eg_valid !== 1'b0) begin
        n_err++;
        $display("FAIL same_cycle_predict_done: eg_valid got %b want 0", o_eg_valid);
      end
      lat = $urandom_range(0, 2);
    end else if (slow) begin
      lat = 40;
    end else begin
      lat = $urandom_range(1, 3);
    end
    repeat (lat) @(negedge clk);
    if (slow) begin
      n_cmp++;
      if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
        n_err++;
        $display("FAIL no_watchdog: timeout/busy got %b%b want 01", o_timeout, o_busy);
      end
    end
    i_predict_done = 1'b1;
    i_predict_action = pa;
    @(negedge clk);
    i_predict_done = 1'b0;
    n_cmp++;
    if (o_eg_valid !== 1'b1 || o_eg_action !== pa || o_eg_train_mode !== 1'b0) begin
      n_err++;
      $display("FAIL eg_request: valid/action/mode got %b/%0d/%b want 1/%0d/0",
               o_eg_valid, o_eg_action, o_eg_train_mode, pa);
    end

    // selector
    if (glitch) begin
      i_eg_valid = 1'b1;
      i_eg_action = ~ca;
      @(negedge clk);
      i_eg_valid = 1'b0;
      n_cmp++;
      if (o_env_valid !== 1'b0) begin
        n_err++;
        $display("FAIL same_cycle_eg_valid: env_valid got %b want 0", o_env_valid);
      end
      lat = $urandom_range(0, 2);
    end else begin
      lat = $urandom_range(1, 3);
    end
    repeat (lat) @(negedge clk);
    i_eg_valid = 1'b1;
    i_eg_action = ca;
    @(negedge clk);
    i_eg_valid = 1'b0;
    n_cmp++;
    if (o_env_valid !== 1'b1 || o_env_action !== ca || o_eg_train_mode !== 1'b1) begin
      n_err++;
      $display("FAIL env_request: valid/action/mode got %b/%0d/%b want 1/%0d/1",
               o_env_valid, o_env_action, o_eg_train_mode, ca);
    end

    // environment
    if (stop) i_stop = 1'b1;
    lat = $urandom_range(0, 3);
    repeat (lat) @(negedge clk);
    i_env_done = 1'b1;
    i_env_terminal = term;
    @(negedge clk);
    i_env_done = 1'b0;
    i_env_terminal = 1'b0;

    // replay write, held until accepted
    lat = $urandom_range(0, 3);
    repeat (lat) @(negedge clk);
    n_cmp++;
    if (o_mem_write !== 1'b1 || o_env_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mem_write_level: write/env_valid got %b/%b want 1/0", o_mem_write, o_env_valid);
    end
    i_mem_ready = 1'b1;
    @(negedge clk);
    i_mem_ready = 1'b0;

    step_m = step_m + 16'd1;
    trans_m = trans_m + 1;
    train = (trans_m == TRAIN_INTERVAL);
    if (train) trans_m = 0;
    n_cmp++;
    if (o_mem_write !== 1'b0 || o_train_start !== train) begin
      n_err++;
      $display("FAIL after_write: mem_write/train_start got %b/%b want 0/%b",
               o_mem_write, o_train_start, train);
    end

    if (train) begin
      n_cmp++;
      if (o_step_count !== step_m) begin
        n_err++;
        $display("FAIL train_step_count: got %0d want %0d", o_step_count, step_m);
      end
      if (glitch) begin
        i_train_done = 1'b1;
        @(negedge clk);
        i_train_done = 1'b0;
        lat = $urandom_range(0, 2);
      end else begin
        lat = $urandom_range(1, 3);
      end
      repeat (lat) @(negedge clk);
      n_cmp++;
      if (o_predict_start !== 1'b0 || o_busy !== 1'b1) begin
        n_err++;
        $display("FAIL train_wait: predict_start/busy got %b/%b want 0/1", o_predict_start, o_busy);
      end
      i_train_done = 1'b1;
      @(negedge clk);
      i_train_done = 1'b0;
    end

    if (term || step_m == 16'(MAX_STEPS)) begin
      ep_m = ep_m + 16'd1;
      step_m = 16'd0;
    end
    exp_go = ~stop;
    n_cmp++;
    if (o_step_count !== step_m || o_episode_count !== ep_m) begin
      n_err++;
      $display("FAIL counters: step/episode got %0d/%0d want %0d/%0d",
               o_step_count, o_episode_count, step_m, ep_m);
    end
    n_cmp++;
    if (o_predict_start !== exp_go || o_busy !== exp_go) begin
      n_err++;
      $display("FAIL step_end: predict_start/busy got %b/%b want %b/%b",
               o_predict_start, o_busy, exp_go, exp_go);
    end
    i_stop = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_predict_start !== 1'b0 || o_eg_valid !== 1'b0 || o_env_valid !== 1'b0 ||
        o_mem_write !== 1'b0 || o_train_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got %b%b%b%b%b want 00000", o_predict_start, o_eg_valid,
               o_env_valid, o_mem_write, o_train_start);
    end
    n_cmp++;
    if (o_eg_train_mode !== 1'b1 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: mode/busy/timeout got %b/%b/%b want 1/0/0",
               o_eg_train_mode, o_busy, o_timeout);
    end
    n_cmp++;
    if (o_step_count !== 16'd0 || o_episode_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", o_step_count, o_episode_count);
    end
    rst = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy got %b want 0", o_busy);
    end
    step_m = 16'd0; ep_m = 16'd0; trans_m = 0;
  endtask

  task automatic test_single_step();
    start_run();
    run_step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_terminal();
    run_step(1'b0, 1'b0, 1'b0, 1'b0);
    run_step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_train_interval();
    run_step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_max_steps();
    for (int k = 0; k < MAX_STEPS; k++) run_step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stop();
    run_step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_idle_stray();
    for (int k = 0; k < 6; k++) begin
      i_predict_done = 1'($urandom_range(0, 1));
      i_eg_valid = 1'($urandom_range(0, 1));
      i_env_done = 1'($urandom_range(0, 1));
      i_mem_ready = 1'($urandom_range(0, 1));
      i_train_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (o_busy !== 1'b0 || o_predict_start !== 1'b0 || o_eg_valid !== 1'b0 ||
          o_mem_write !== 1'b0 || o_train_start !== 1'b0 ||
          o_step_count !== step_m || o_episode_count !== ep_m) begin
        n_err++;
        $display("FAIL idle_stray: busy %b pulses %b%b%b%b step %0d ep %0d want 0 0000 %0d %0d",
                 o_busy, o_predict_start, o_eg_valid, o_mem_write, o_train_start,
                 o_step_count, o_episode_count, step_m, ep_m);
      end
    end
    clear_inputs();
  endtask

  task automatic test_no_timeout();
`ifndef DQN_STEP_TIMEOUT_EN
    start_run();
    run_step(1'b0, 1'b1, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_random();
    start_run();
    for (int k = 0; k < 24; k++) begin
      run_step(($urandom_range(0, 7) == 0), (k == 23), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_midstep();
    start_run();
    @(negedge clk);
    i_predict_done = 1'b1;
    @(negedge clk);
    i_predict_done = 1'b0;
    @(negedge clk);
    i_eg_valid = 1'b1;
    @(negedge clk);
    i_eg_valid = 1'b0;
    i_env_done = 1'b1;
    @(negedge clk);
    i_env_done = 1'b0;
    n_cmp++;
    if (o_mem_write !== 1'b1) begin
      n_err++;
      $display("FAIL midstep_reach_store: mem_write got %b want 1", o_mem_write);
    end
    rst = 1'b1;
    i_mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_mem_ready = 1'b0;
    step_m = 16'd0; ep_m = 16'd0; trans_m = 0;
    n_cmp++;
    if (o_mem_write !== 1'b0 || o_busy !== 1'b0 || o_step_count !== 16'd0 ||
        o_episode_count !== 16'd0) begin
      n_err++;
      $display("FAIL midstep_reset: write/busy/step/ep got %b/%b/%0d/%0d want 0/0/0/0",
               o_mem_write, o_busy, o_step_count, o_episode_count);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
`ifdef DQN_STEP_TIMEOUT_EN
    start_run();
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    n_cmp++;
    if (o_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: got %b want 0", o_timeout);
    end
    @(negedge clk);
    n_cmp++;
    if (o_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_set: got %b want 1", o_timeout);
    end
    i_predict_done = 1'b1;
    @(negedge clk);
    i_predict_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_eg_valid !== 1'b0 || o_timeout !== 1'b1 || o_predict_start !== 1'b0) begin
      n_err++;
      $display("FAIL error_state: eg_valid/timeout/predict got %b/%b/%b want 0/1/0",
               o_eg_valid, o_timeout, o_predict_start);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: timeout/busy got %b/%b want 0/0", o_timeout, o_busy);
    end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    step_m = 16'd0;
    ep_m = 16'd0;
    trans_m = 0;
    test_reset();
    test_single_step();
    test_terminal();
    test_train_interval();
    test_max_steps();
    test_stop();
    test_idle_stray();
    test_no_timeout();
    test_random();
    test_reset_midstep();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
